// File: rtl/ad5791_ctrl.sv
// AD5791 DAC front end: sample FIFO plus SPI frame engine with a control-register init frame.
// Define AD5791_LDAC_EN to pulse ldac_n after each DAC-register frame; otherwise ldac_n is tied low.
module ad5791_ctrl #(
    parameter int                   DATA_NBIT = 20,
    parameter int                   FIFO_AW   = 2,
    parameter int                   SCLK_HDIV = 2,
    parameter int                   SYNC_GAP  = 4,
    parameter logic [DATA_NBIT-1:0] CTRL_WORD = 20'h00012
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 dac_start,
    input  logic                 dac_en,
    input  logic                 dac_dv,
    input  logic [DATA_NBIT-1:0] dac_data,
    output logic                 dac_waitrequest,
    output logic                 sclk,
    output logic                 sync_n,
    output logic                 sdin,
    output logic                 ldac_n,
    output logic                 busy,
    output logic                 underrun,
    output logic                 overflow
);
    // state | meaning
    // OFF   | disabled, SPI idle
    // INIT  | shifting the control-register frame
    // RUN   | enabled, waiting for dac_start
    // SHIFT | shifting a DAC-register frame
    // GAP   | sync_n high between frames
    typedef enum logic [2:0] {S_OFF, S_INIT, S_RUN, S_SHIFT, S_GAP} state_t;

    localparam int FRAME_NBIT = DATA_NBIT + 4;
    localparam int DEPTH      = 2**FIFO_AW;
`ifdef AD5791_LDAC_EN
    localparam int GAP_LEN = (SYNC_GAP > 2*SCLK_HDIV + 1) ? SYNC_GAP : 2*SCLK_HDIV + 1;
`else
    localparam int GAP_LEN = SYNC_GAP;
`endif
    localparam int BW = $clog2(FRAME_NBIT);
    localparam int HW = $clog2(SCLK_HDIV + 1);
    localparam int GW = $clog2(GAP_LEN + 1);
    localparam logic [BW-1:0]      BIT_LD   = BW'(FRAME_NBIT - 1);
    localparam logic [HW-1:0]      HDIV_LD  = HW'(SCLK_HDIV - 1);
    localparam logic [GW-1:0]      GAP_LD   = GW'(GAP_LEN - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [2:0]         ADDR_DAC  = 3'b001;
    localparam logic [2:0]         ADDR_CTRL = 3'b010;

    logic [DATA_NBIT-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count, count_nxt;
    logic                 full, empty, push, pop, underrun_set;

    state_t                state, state_nxt;
    logic [FRAME_NBIT-2:0] shreg, shreg_nxt;
    logic [FRAME_NBIT-1:0] frame;
    logic [BW-1:0]         bit_cnt, bit_nxt;
    logic [HW-1:0]         hdiv_cnt, hdiv_nxt;
    logic [GW-1:0]         gap_cnt, gap_nxt;
    logic                  sclk_nxt, sync_n_nxt, sdin_nxt, stop_q, stop_nxt, load;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    assign push  = dac_dv && dac_en && (!full || pop);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge mclk) begin
        if (push)
            mem[wr_ptr] <= dac_data;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            dac_waitrequest <= 1'b0;
            underrun        <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            if (!dac_en) begin
                wr_ptr          <= '0;
                rd_ptr          <= '0;
                count           <= '0;
                dac_waitrequest <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count           <= count_nxt;
                dac_waitrequest <= (count_nxt == FULL_CNT);
            end
            if (dac_dv && dac_en && full && !pop)
                overflow <= 1'b1;
            if (underrun_set)
                underrun <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_nxt      = bit_cnt;
        hdiv_nxt     = hdiv_cnt;
        gap_nxt      = gap_cnt;
        sclk_nxt     = sclk;
        sync_n_nxt   = sync_n;
        sdin_nxt     = sdin;
        stop_nxt     = stop_q || !dac_en;
        pop          = 1'b0;
        underrun_set = 1'b0;
        load         = 1'b0;
        frame        = '0;
        case (state)
            S_OFF: begin
                // level start also restarts if dac_en came back while the last frame drained
                stop_nxt = 1'b0;
                if (dac_en) begin
                    state_nxt = S_INIT;
                    load      = 1'b1;
                    frame     = {1'b0, ADDR_CTRL, CTRL_WORD};
                end
            end
            S_RUN: begin
                if (!dac_en)
                    state_nxt = S_OFF;
                else if (dac_start) begin
                    if (empty)
                        underrun_set = 1'b1;
                    else begin
                        pop       = 1'b1;
                        state_nxt = S_SHIFT;
                        load      = 1'b1;
                        frame     = {1'b0, ADDR_DAC, mem[rd_ptr]};
                    end
                end
            end
            S_INIT, S_SHIFT: begin
                if (hdiv_cnt != '0)
                    hdiv_nxt = hdiv_cnt - 1'b1;
                else begin
                    hdiv_nxt = HDIV_LD;
                    if (sclk)
                        sclk_nxt = 1'b0;
                    else if (bit_cnt == '0) begin
                        sclk_nxt   = 1'b1;
                        sync_n_nxt = 1'b1;
                        sdin_nxt   = 1'b0;
                        gap_nxt    = GAP_LD;
                        state_nxt  = S_GAP;
                    end else begin
                        sclk_nxt  = 1'b1;
                        sdin_nxt  = shreg[FRAME_NBIT-2];
                        shreg_nxt = {shreg[FRAME_NBIT-3:0], 1'b0};
                        bit_nxt   = bit_cnt - 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt != '0)
                    gap_nxt = gap_cnt - 1'b1;
                else
                    state_nxt = stop_nxt ? S_OFF : S_RUN;
            end
            default: state_nxt = S_OFF;
        endcase
        if (load) begin
            shreg_nxt  = frame[FRAME_NBIT-2:0];
            sdin_nxt   = frame[FRAME_NBIT-1];
            sync_n_nxt = 1'b0;
            sclk_nxt   = 1'b1;
            hdiv_nxt   = HDIV_LD;
            bit_nxt    = BIT_LD;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state    <= S_OFF;
            shreg    <= '0;
            bit_cnt  <= '0;
            hdiv_cnt <= '0;
            gap_cnt  <= '0;
            sclk     <= 1'b1;
            sync_n   <= 1'b1;
            sdin     <= 1'b0;
            stop_q   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_nxt;
            hdiv_cnt <= hdiv_nxt;
            gap_cnt  <= gap_nxt;
            sclk     <= sclk_nxt;
            sync_n   <= sync_n_nxt;
            sdin     <= sdin_nxt;
            stop_q   <= stop_nxt;
            busy     <= (state_nxt inside {S_INIT, S_SHIFT, S_GAP});
        end
    end

`ifdef AD5791_LDAC_EN
    localparam int LW = $clog2(2*SCLK_HDIV + 1);
    localparam logic [LW-1:0] LDAC_LD = LW'(2*SCLK_HDIV);
    logic [LW-1:0] ldac_cnt;

    // loaded as sync_n rises, so the low pulse begins one cycle later
    always_ff @(posedge mclk) begin
        if (rst) begin
            ldac_cnt <= '0;
            ldac_n   <= 1'b1;
        end else if (state == S_SHIFT && state_nxt == S_GAP) begin
            ldac_cnt <= LDAC_LD;
            ldac_n   <= 1'b1;
        end else if (ldac_cnt != '0) begin
            ldac_cnt <= ldac_cnt - 1'b1;
            ldac_n   <= 1'b0;
        end else
            ldac_n <= 1'b1;
    end
`else
    always_ff @(posedge mclk) begin
        if (rst)
            ldac_n <= 1'b1;
        else
            ldac_n <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_ad5791_ctrl.sv
// Scoreboard bench for ad5791_ctrl: directed stimulus queues expected SPI frames, a monitor decodes sdin.
module tb_ad5791_ctrl;
    localparam int H = 2;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        dac_start = 1'b0;
    logic        dac_en = 1'b0;
    logic        dac_dv = 1'b0;
    logic [19:0] dac_data = '0;
    logic        dac_waitrequest, sclk, sync_n, sdin, ldac_n, busy, underrun, overflow;

    always #5 mclk = ~mclk;

    ad5791_ctrl #(
        .DATA_NBIT(20), .FIFO_AW(2), .SCLK_HDIV(H), .SYNC_GAP(4), .CTRL_WORD(20'h00012)
    ) dut (
        .mclk(mclk), .rst(rst), .dac_start(dac_start), .dac_en(dac_en), .dac_dv(dac_dv),
        .dac_data(dac_data), .dac_waitrequest(dac_waitrequest), .sclk(sclk), .sync_n(sync_n),
        .sdin(sdin), .ldac_n(ldac_n), .busy(busy), .underrun(underrun), .overflow(overflow)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];
    int          n_dac_exp = 0;
    int          n_ldac_pulses = 0;
    int          ldac_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic push(input logic [19:0] d);
        dac_dv   = 1'b1;
        dac_data = d;
        tick();
        dac_dv   = 1'b0;
    endtask

    task automatic start_frame(input logic [23:0] e, input string name);
        exp_q.push_back(e);
        n_dac_exp++;
        dac_start = 1'b1;
        tick();
        dac_start = 1'b0;
        chk(name, sync_n, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (busy && i < 1000) begin
            tick();
            i++;
        end
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    // SPI monitor: decode each frame and compare against the scoreboard
    logic        sync_prev = 1'b1, sclk_prev = 1'b1, ldac_prev = 1'b1, last_dac = 1'b0;
    logic [23:0] cap = '0;
    logic [23:0] e;
    int          nbits = 0, low_cnt = 0, since_rise = 0, rst_low = 0;
    int          ldac_start = 0, ldac_len = 0;

    always @(negedge mclk) begin
        if (rst) begin
            sync_prev = sync_n;
            sclk_prev = sclk;
            ldac_prev = ldac_n;
            rst_low   = 0;
        end else begin
            rst_low++;
            if (!sync_n && sync_prev) begin
                low_cnt = 0;
                nbits   = 0;
                cap     = '0;
            end
            if (!sync_n) begin
                low_cnt++;
                if (sclk_prev && !sclk) begin
                    cap = {cap[22:0], sdin};
                    nbits++;
                end
            end
            if (sync_n && !sync_prev) begin
                since_rise = 0;
                last_dac   = (cap[22:20] == 3'b001);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got %h want none", cap);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_data", cap, e);
                    chk("frame_bits", nbits, 24);
                    chk("sync_low_cycles", low_cnt, 48*H);
                end
            end else
                since_rise++;
`ifdef AD5791_LDAC_EN
            if (!ldac_n && ldac_prev) begin
                ldac_start = since_rise;
                ldac_len   = 0;
            end
            if (!ldac_n)
                ldac_len++;
            if (ldac_n && !ldac_prev) begin
                n_ldac_pulses++;
                chk("ldac_delay", ldac_start, 1);
                chk("ldac_len", ldac_len, 2*H);
                chk("ldac_after_dac_frame", last_dac, 1'b1);
            end
`else
            if (rst_low >= 2 && ldac_n !== 1'b0)
                ldac_bad++;
`endif
            sync_prev = sync_n;
            sclk_prev = sclk;
            ldac_prev = ldac_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_low;
        logic [19:0] vals[5];
        vals[0] = 20'h11111; vals[1] = 20'h22222; vals[2] = 20'h33333;
        vals[3] = 20'h44444; vals[4] = 20'h55555;

        repeat (3) tick();
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_sync_n", sync_n, 1'b1);
        chk("rst_sdin", sdin, 1'b0);
        chk("rst_ldac_n", ldac_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_waitreq", dac_waitrequest, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        chk("off_sync_n", sync_n, 1'b1);
        chk("off_busy", busy, 1'b0);

        // T1: control-register init frame
        exp_q.push_back(24'h200012);
        dac_en = 1'b1;
        tick();
        chk("t1_latency", sync_n, 1'b0);
        chk("t1_busy", busy, 1'b1);
        wait_idle("t1");
        chk("t1_sclk_idle", sclk, 1'b1);
        chk("t1_sync_idle", sync_n, 1'b1);

        // T2: single sample
        push(20'hABCDE);
        start_frame(24'h1ABCDE, "t2_latency");
        wait_idle("t2");

        // T3: overfill, then drain in order
        dac_dv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dac_data = vals[i];
            tick();
            if (i == 3) begin
                chk("t3_waitreq_full", dac_waitrequest, 1'b1);
                chk("t3_no_overflow_yet", overflow, 1'b0);
            end
        end
        dac_dv = 1'b0;
        chk("t3_overflow", overflow, 1'b1);
        chk("t3_waitreq_held", dac_waitrequest, 1'b1);
        for (int i = 0; i < 4; i++) begin
            start_frame({4'h1, vals[i]}, "t3_latency");
            if (i == 0)
                chk("t3_waitreq_after_pop", dac_waitrequest, 1'b0);
            wait_idle("t3");
        end
        chk("t3_overflow_sticky", overflow, 1'b1);

        // T4b: dac_start during SHIFT is ignored
        push(20'h00001);
        push(20'hFFFFF);
        start_frame(24'h100001, "t4b_latency");
        repeat (10) tick();
        dac_start = 1'b1;
        tick();
        dac_start = 1'b0;
        wait_idle("t4b_a");
        chk("t4b_no_underrun", underrun, 1'b0);
        start_frame(24'h1FFFFF, "t4b_latency2");
        wait_idle("t4b_b");

        // T4: start with empty FIFO
        dac_start = 1'b1;
        tick();
        dac_start = 1'b0;
        chk("t4_no_frame", sync_n, 1'b1);
        chk("t4_underrun", underrun, 1'b1);
        chk("t4_not_busy", busy, 1'b0);
        seen_low = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!sync_n) seen_low = 1;
        end
        chk("t4_no_sync_edge", seen_low, 0);
        chk("t4_underrun_sticky", underrun, 1'b1);

        // T5: disable mid-SHIFT
        push(20'h5A5A5);
        push(20'h0F0F0);
        start_frame(24'h15A5A5, "t5_latency");
        repeat (20) tick();
        dac_en = 1'b0;
        tick();
        chk("t5_busy_continues", busy, 1'b1);
        chk("t5_sync_still_low", sync_n, 1'b0);
        push(20'h77777);
        wait_idle("t5");
        repeat (3) tick();
        chk("t5_off_sync_n", sync_n, 1'b1);
        chk("t5_off_waitreq", dac_waitrequest, 1'b0);
        exp_q.push_back(24'h200012);
        dac_en = 1'b1;
        tick();
        chk("t5_reinit_latency", sync_n, 1'b0);
        wait_idle("t5_reinit");
        dac_start = 1'b1;
        tick();
        dac_start = 1'b0;
        chk("t5_fifo_flushed", sync_n, 1'b1);
        repeat (5) tick();
        chk("t5_still_idle", busy, 1'b0);

        repeat (20) tick();
        chk("exp_queue_empty", exp_q.size(), 0);
`ifdef AD5791_LDAC_EN
        chk("ldac_pulse_count", n_ldac_pulses, n_dac_exp);
`else
        chk("ldac_tied_low_violations", ldac_bad, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
